// File: rtl/mem_arbiter.sv
// Shares one memory bus between the instruction and data ports of the core.
// Data side wins by default; a starvation counter forces an ibus grant.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic        i_data_ok,
    output logic [31:0] i_data,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic        d_data_ok,
    output logic [63:0] d_data,
    output logic        m_valid,
    output logic        m_write,
    output logic [63:0] m_addr,
    output logic [2:0]  m_size,
    output logic [7:0]  m_strobe,
    output logic [63:0] m_wdata,
    input  logic        m_ready,
    input  logic [63:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        grant_i, grant_d, ibus_force;
    logic        m_valid_q, m_write_q;
    logic [63:0] m_addr_q, m_wdata_q;
    logic [2:0]  m_size_q;
    logic [7:0]  m_strobe_q;

    always_comb begin
        ibus_force = (starve_cnt_q >= LIMIT);
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        if (state_q == IDLE) begin
            if (ibus_force && i_valid) grant_i = 1'b1;
            else if (d_valid)          grant_d = 1'b1;
            else if (i_valid)          grant_i = 1'b1;
        end

        starve_cnt_d = starve_cnt_q;
        if (grant_i) begin
            starve_cnt_d = '0;
        end else if (grant_d) begin
            if (!i_valid)                starve_cnt_d = '0;
            else if (starve_cnt_q != '1) starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            m_valid_q    <= 1'b0;
            m_write_q    <= 1'b0;
            m_addr_q     <= '0;
            m_size_q     <= '0;
            m_strobe_q   <= '0;
            m_wdata_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        state_q    <= BUSY_I;
                        m_valid_q  <= 1'b1;
                        m_write_q  <= 1'b0;
                        m_addr_q   <= i_addr;
                        m_size_q   <= 3'd2;
                        m_strobe_q <= '0;
                        m_wdata_q  <= '0;
                    end else if (grant_d) begin
                        state_q    <= BUSY_D;
                        m_valid_q  <= 1'b1;
                        m_write_q  <= |d_strobe;
                        m_addr_q   <= d_addr;
                        m_size_q   <= d_size;
                        m_strobe_q <= d_strobe;
                        m_wdata_q  <= d_wdata;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Request fields stay put after completion; only m_valid drops.
                    if (m_ready) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Completion is gated by the requester's current valid so an abandoned
    // request finishes on the memory side without a response pulse.
    always_comb begin
        i_data_ok = (state_q == BUSY_I) && m_ready && i_valid;
        d_data_ok = (state_q == BUSY_D) && m_ready && d_valid;
        i_data    = '0;
        d_data    = '0;
        if (i_data_ok) i_data = m_addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
        if (d_data_ok) d_data = m_rdata;
    end

    assign m_valid  = m_valid_q;
    assign m_write  = m_write_q;
    assign m_addr   = m_addr_q;
    assign m_size   = m_size_q;
    assign m_strobe = m_strobe_q;
    assign m_wdata  = m_wdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction port (ibus) and data port (dbus).
- Sits between the core and the memory or cache interconnect.
- Latches one request at a time, holds it on the memory bus until completion, and routes the response back to the winning requester.
- Fixed data-side priority plus a starvation counter so instruction fetch always makes progress.

Parameters:
- STARVE_LIMIT, 4: consecutive dbus grants while ibus is waiting before ibus is forced to win the next arbitration (legal range 1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  ibus request; held high until i_data_ok
- i_addr  in  64  ibus fetch address, 4-byte aligned
- i_data_ok  out  1  ibus completion pulse
- i_data  out  32  fetched instruction word
- d_valid  in  1  dbus request; held high until d_data_ok
- d_addr  in  64  dbus address
- d_size  in  3  dbus access size code, log2 bytes (0..3)
- d_strobe  in  8  byte write enables; all zero means read
- d_wdata  in  64  store data
- d_data_ok  out  1  dbus completion pulse
- d_data  out  64  load data
- m_valid  out  1  memory request valid
- m_write  out  1  memory request is a write
- m_addr  out  64  memory address
- m_size  out  3  memory access size code
- m_strobe  out  8  memory byte enables
- m_wdata  out  64  memory write data
- m_ready  in  1  memory completion pulse; m_rdata is valid in the same cycle
- m_rdata  in  64  memory read data

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Reset value is IDLE.
- Reset values:
  - m_valid=0, m_write=0, and all m_* data fields =0.
  - starve_cnt=0.
  - i_data_ok=0, d_data_ok=0, i_data=0, d_data=0.
- Arbitration happens only in IDLE, on the clock edge:
  - If ibus_force (starve_cnt>=STARVE_LIMIT) and i_valid, grant I.
  - Else if d_valid, grant D.
  - Else if i_valid, grant I.
  - Else stay IDLE.
- On a grant:
  - Register the request into the m_* outputs and assert m_valid from the next cycle.
  - An ibus grant drives m_write=0, m_size=3'd2, m_strobe=0, and m_addr=i_addr.
  - A dbus grant drives m_write=|d_strobe and passes d_size, d_strobe, d_wdata and d_addr through unchanged.
- Latency: request high in cycle N while IDLE gives m_valid high in cycle N+1 at the earliest.
- While in BUSY_*, all m_* outputs are held stable. New requester activity is ignored.
- Completion on m_ready in BUSY_I:
  - i_data_ok=1 combinationally in that cycle.
  - i_data = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0].
  - Next state is IDLE and m_valid drops.
- Completion on m_ready in BUSY_D:
  - d_data_ok=1 and d_data=m_rdata, combinationally in that cycle.
  - Next state is IDLE.
- i_data and d_data are 0 whenever the matching data_ok is 0.
- The cycle after any completion is always IDLE, which gives one bubble. Requesters present their next address in that cycle, so a stale request is never re-issued.
- Starvation counter:
  - A D grant while i_valid=1 increments starve_cnt, saturating at 15.
  - An I grant clears starve_cnt.
  - A D grant with i_valid=0 clears starve_cnt.
- Abandoned request: if the granted requester drops valid before m_ready, the transaction still completes on the memory side. Its data_ok is suppressed, because data_ok is gated by the requester's current valid.
- m_ready while IDLE is ignored. It produces no data_ok and no state change.
- i_data_ok and d_data_ok are never high in the same cycle.
- Reset mid-transaction: state goes to IDLE and m_valid=0 on the next edge. The memory side must tolerate the aborted request.

Test Plan:
- Single fetch:
  - Stimulus: i_valid=1, i_addr=0x8000_0004; memory returns m_ready 3 cycles after m_valid with m_rdata=0x1111_2222_3333_4444.
  - Required: m_valid rises 1 cycle after the request, m_addr=0x8000_0004, m_size=2, m_write=0; i_data_ok pulses once with i_data=0x1111_2222; m_valid low the cycle after.
- Simultaneous requests:
  - Stimulus: i_valid=d_valid=1 in the same cycle; d_addr=0x8010_0008, d_strobe=0xFF, d_wdata=0xDEAD.
  - Required: D is granted first with m_write=1 and m_strobe=0xFF; after d_data_ok, one IDLE cycle, then the I request is issued.
- Starvation:
  - Stimulus: i_valid held high while d_valid is re-asserted after every completion.
  - Required: after 4 D grants, the 5th grant goes to I and starve_cnt returns to 0.
- Abandon:
  - Stimulus: an I grant, then i_valid dropped before m_ready.
  - Required: no i_data_ok; state returns to IDLE after m_ready.
- Spurious and reset:
  - Stimulus: m_ready pulsed while IDLE.
  - Required: no outputs change.
  - Stimulus: reset asserted in BUSY_D.
  - Required: m_valid=0 and no d_data_ok on the next cycle.
